// File: rtl/fetch_decode_stage.sv
// Fetch/decode front end: drives a 1-cycle-latency instruction RAM, steps the PC and registers
// decoded fields with stall, redirect/squash, HALT stop and loader pass-through. Option: FD_INSTR_COUNT_EN.
module fetch_decode_stage #(
   parameter int ADDR_W = 9,
   parameter int DATA_W = 32,
   parameter int VALC_W = 16,
   parameter logic [ADDR_W-1:0] PC_RESET = '0
) (
   input  logic              clock,
   input  logic              reset_n,
   input  logic              working,
   input  logic [ADDR_W-1:0] load_addr,
   input  logic              load_wr,
   input  logic [DATA_W-1:0] load_wdata,
   input  logic              stall,
   input  logic              redirect,
   input  logic [ADDR_W-1:0] redirect_pc,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_wr,
   output logic [DATA_W-1:0] mem_wdata,
   output logic              mem_rd,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              d_valid,
   output logic [3:0]        d_icode,
   output logic [3:0]        d_ifun,
   output logic [3:0]        d_rA,
   output logic [3:0]        d_rB,
   output logic [VALC_W-1:0] d_valC,
   output logic [ADDR_W-1:0] d_pc,
   output logic              halted
`ifdef FD_INSTR_COUNT_EN
   ,output logic [31:0]      instr_count
`endif
);

   // state    | meaning
   // S_IDLE   | loader owns the RAM, no fetch
   // S_RUN    | fetching and decoding one word per cycle
   // S_HALTED | HALT decoded, fetch stopped until working drops
   typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_HALTED = 2'd2} state_t;

   state_t            state, state_nxt;
   logic [ADDR_W-1:0] pc, last_addr, issue_addr;
   logic              rsp_pend;
   logic              run_active, capture, halting;

   assign run_active = (state == S_RUN) & working;
   assign capture    = run_active & rsp_pend & ~stall & ~redirect;
   assign halting    = capture & (mem_rdata[DATA_W-1 -: 4] == 4'h0);

   always_ff @(posedge clock) begin
      if (!reset_n) state <= S_IDLE;
      else          state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         S_IDLE:   if (working) state_nxt = S_RUN;
         S_RUN: begin
            if (!working)    state_nxt = S_IDLE;
            else if (halting) state_nxt = S_HALTED;
         end
         S_HALTED: if (!working) state_nxt = S_IDLE;
         default:  state_nxt = S_IDLE;
      endcase
   end

   // A stalled slot re-reads last_addr so mem_rdata is still valid when the stall releases.
   always_comb begin
      issue_addr = pc;
      if (redirect)   issue_addr = redirect_pc;
      else if (stall) issue_addr = last_addr;
      mem_addr  = working ? issue_addr : load_addr;
      mem_rd    = (state == S_RUN) & ~halting;
      mem_wr    = load_wr & ~working;
      mem_wdata = load_wdata;
   end

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         pc        <= PC_RESET;
         last_addr <= '0;
         rsp_pend  <= 1'b0;
         d_valid   <= 1'b0;
         d_icode   <= '0;
         d_ifun    <= '0;
         d_rA      <= '0;
         d_rB      <= '0;
         d_valC    <= '0;
         d_pc      <= '0;
         halted    <= 1'b0;
      end else if (run_active) begin
         if (redirect) begin
            pc        <= redirect_pc + ADDR_W'(1);
            last_addr <= redirect_pc;
            rsp_pend  <= 1'b1;
            d_valid   <= 1'b0;
         end else if (!stall) begin
            if (rsp_pend) begin
               d_icode <= mem_rdata[DATA_W-1 -: 4];
               d_ifun  <= mem_rdata[DATA_W-5 -: 4];
               d_rA    <= mem_rdata[DATA_W-9 -: 4];
               d_rB    <= mem_rdata[DATA_W-13 -: 4];
               d_valC  <= mem_rdata[VALC_W-1:0];
               d_pc    <= last_addr;
            end
            d_valid <= rsp_pend;
            if (halting) begin
               halted   <= 1'b1;
               rsp_pend <= 1'b0;
            end else begin
               pc        <= pc + ADDR_W'(1);
               last_addr <= pc;
               rsp_pend  <= 1'b1;
            end
         end
      end else if (state != S_IDLE && !working) begin
         d_valid  <= 1'b0;
         rsp_pend <= 1'b0;
         halted   <= 1'b0;
      end else if (state == S_HALTED) begin
         d_valid <= 1'b0;
      end
   end

`ifdef FD_INSTR_COUNT_EN
   always_ff @(posedge clock) begin
      if (!reset_n)     instr_count <= '0;
      else if (capture) instr_count <= instr_count + 32'd1;
   end
`endif

endmodule
